time_counter_bcd: RTL and testbench
===================================

// Module: time_counter_bcd
// PURPOSE
//  Timekeeping core upstream of the 7-segment display driver `clock`.
//  - Divides the system clock to a 1 Hz enable.
//  - Keeps 24-hour time (HH:MM:SS) in BCD.
//  - Presents four BCD digits (HH:MM) plus a colon-blink bit to the display multiplexer.
// PARAMETERS
//  TICKS_PER_SEC  100_000_000  clk cycles per second; must be >= 2 (benches use 4)
//  PS_W           27           prescaler width; must satisfy 2**PS_W >= TICKS_PER_SEC
// PORTS
//  clk        in   1  system clock; all logic on posedge
//  reset      in   1  synchronous, active-high reset
//  inc_min    in   1  1-cycle pulse: advance minutes (set mode, see CONFIGURATION)
//  inc_hour   in   1  1-cycle pulse: advance hours (set mode, see CONFIGURATION)
//  hour_tens  out  4  BCD 0..2
//  hour_ones  out  4  BCD 0..9 (0..3 when hour_tens==2)
//  min_tens   out  4  BCD 0..5
//  min_ones   out  4  BCD 0..9
//  sec_pulse  out  1  high for exactly 1 cycle per elapsed second
//  colon      out  1  seconds LSB; toggles each second; drives the colon/DP
// BEHAVIOUR
//  Reset
//  - reset=1 at a posedge clears all state: prescaler=0, time 00:00:00.
//  - All digits are 0, and sec_pulse, colon are 0, from the cycle after reset.
//  - Reset overrides every other input, including mid-second and mid-set.
//  Prescaler
//  - Counts 0..TICKS_PER_SEC-1.
//  - At the edge where count==TICKS_PER_SEC-1: count->0, seconds advance, and sec_pulse=1
//    for the following cycle (registered).
//  - First sec_pulse after reset release therefore occurs TICKS_PER_SEC cycles later.
//  Time chain (all BCD, all outputs registered)
//  - sec_ones 9->0 carries to sec_tens; sec_tens 5->0 carries to min_ones.
//  - min_ones 9->0 carries to min_tens; min_tens 5->0 carries to hours.
//  - Hours: x9->(x+1)0; 23->00.
//  - Rollover 23:59:59 -> 00:00:00 in a single tick; all digits change on the same edge.
//  - Digit outputs never show a non-BCD value or a value out of range, including in
//    intermediate cycles.
//  - colon = sec_ones[0].
// CONFIGURATION
//  Macro CLOCK_SET_EN
//  - Defined:
//    - inc_min=1: minutes +1 mod 60 with NO carry into hours.
//    - inc_hour=1: hours +1 mod 24.
//    - Either pulse also clears seconds to 00 and the prescaler to 0; no sec_pulse that cycle.
//    - Set pulse coincident with prescaler terminal count: set wins, the tick is discarded.
//    - inc_min and inc_hour high together: both applied on the same edge.
//    - An input held high for N cycles applies N increments.
//  - Not defined:
//    - inc_min and inc_hour are ignored; ports remain present for a fixed interface.
//    - Timekeeping is free-running from reset only.
// TESTING (TICKS_PER_SEC=4)
//  1. Reset pulse for 1 cycle -> next cycle all digits 0, sec_pulse=0, colon=0;
//     first sec_pulse 4 cycles after reset release.
//  2. Run 240 cycles after reset -> min_ones=1, min_tens=0, colon=0;
//     exactly 60 sec_pulse events counted.
//  3. CLOCK_SET_EN: 23 inc_hour + 59 inc_min pulses -> 23:59;
//     then 240 cycles -> 00:00 with all four digits changing on one edge.
//  4. CLOCK_SET_EN: 60 inc_min pulses from 00:00 -> 00:00 (no hour carry);
//     inc_hour on the terminal-count cycle -> seconds=0, no sec_pulse that cycle.
//  5. Assert reset mid-second at time 12:34 -> 00:00:00, prescaler restarts;
//     next sec_pulse 4 cycles after release.
//  6. Macro undefined: toggle inc_min/inc_hour for 100 cycles -> digits identical to a
//     run with both held at 0.

Source files
------------

// File: rtl/time_counter_bcd.sv
// 24-hour BCD timekeeper (HH:MM:SS) with a 1 Hz prescaler, feeding the HH:MM display mux.
// Optional manual set inputs are enabled by defining CLOCK_SET_EN.
module time_counter_bcd #(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int PS_W          = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc_min,
  input  logic       inc_hour,
  output logic [3:0] hour_tens,
  output logic [3:0] hour_ones,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic       sec_pulse,
  output logic       colon
);

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICKS_PER_SEC - 1);

  logic [PS_W-1:0] ps_q, ps_d;
  logic [3:0]      sec_ones_q, sec_ones_d;
  logic [3:0]      sec_tens_q, sec_tens_d;
  logic [3:0]      min_ones_q, min_ones_d;
  logic [3:0]      min_tens_q, min_tens_d;
  logic [3:0]      hour_ones_q, hour_ones_d;
  logic [3:0]      hour_tens_q, hour_tens_d;
  logic            sec_pulse_q, sec_pulse_d;
  logic            tick;
  logic            set_req;
  logic            set_min;
  logic            set_hour;

`ifdef CLOCK_SET_EN
  assign set_min  = inc_min;
  assign set_hour = inc_hour;
`else
  // Ports stay for a fixed interface; the pulses have no effect in this build.
  logic unused_inc;
  assign unused_inc = inc_min ^ inc_hour;
  assign set_min    = 1'b0;
  assign set_hour   = 1'b0;
`endif

  assign set_req = set_min | set_hour;
  assign tick    = (ps_q == PS_LAST);

  always_comb begin
    ps_d        = ps_q;
    sec_ones_d  = sec_ones_q;
    sec_tens_d  = sec_tens_q;
    min_ones_d  = min_ones_q;
    min_tens_d  = min_tens_q;
    hour_ones_d = hour_ones_q;
    hour_tens_d = hour_tens_q;
    sec_pulse_d = 1'b0;

    if (set_req) begin
      // A set pulse restarts the second and swallows any coincident tick.
      ps_d       = '0;
      sec_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      if (set_min) begin
        if (min_ones_q == 4'd9) begin
          min_ones_d = 4'd0;
          min_tens_d = (min_tens_q == 4'd5) ? 4'd0 : min_tens_q + 4'd1;
        end else begin
          min_ones_d = min_ones_q + 4'd1;
        end
      end
      if (set_hour) begin
        if (hour_tens_q == 4'd2 && hour_ones_q == 4'd3) begin
          hour_tens_d = 4'd0;
          hour_ones_d = 4'd0;
        end else if (hour_ones_q == 4'd9) begin
          hour_tens_d = hour_tens_q + 4'd1;
          hour_ones_d = 4'd0;
        end else begin
          hour_ones_d = hour_ones_q + 4'd1;
        end
      end
    end else if (tick) begin
      ps_d        = '0;
      sec_pulse_d = 1'b1;
      if (sec_ones_q != 4'd9) begin
        sec_ones_d = sec_ones_q + 4'd1;
      end else begin
        sec_ones_d = 4'd0;
        if (sec_tens_q != 4'd5) begin
          sec_tens_d = sec_tens_q + 4'd1;
        end else begin
          sec_tens_d = 4'd0;
          if (min_ones_q != 4'd9) begin
            min_ones_d = min_ones_q + 4'd1;
          end else begin
            min_ones_d = 4'd0;
            if (min_tens_q != 4'd5) begin
              min_tens_d = min_tens_q + 4'd1;
            end else begin
              min_tens_d = 4'd0;
              if (hour_tens_q == 4'd2 && hour_ones_q == 4'd3) begin
                hour_tens_d = 4'd0;
                hour_ones_d = 4'd0;
              end else if (hour_ones_q == 4'd9) begin
                hour_tens_d = hour_tens_q + 4'd1;
                hour_ones_d = 4'd0;
              end else begin
                hour_ones_d = hour_ones_q + 4'd1;
              end
            end
          end
        end
      end
    end else begin
      ps_d = ps_q + PS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ps_q        <= '0;
      sec_ones_q  <= 4'd0;
      sec_tens_q  <= 4'd0;
      min_ones_q  <= 4'd0;
      min_tens_q  <= 4'd0;
      hour_ones_q <= 4'd0;
      hour_tens_q <= 4'd0;
      sec_pulse_q <= 1'b0;
    end else begin
      ps_q        <= ps_d;
      sec_ones_q  <= sec_ones_d;
      sec_tens_q  <= sec_tens_d;
      min_ones_q  <= min_ones_d;
      min_tens_q  <= min_tens_d;
      hour_ones_q <= hour_ones_d;
      hour_tens_q <= hour_tens_d;
      sec_pulse_q <= sec_pulse_d;
    end
  end

  assign hour_tens = hour_tens_q;
  assign hour_ones = hour_ones_q;
  assign min_tens  = min_tens_q;
  assign min_ones  = min_ones_q;
  assign sec_pulse = sec_pulse_q;
  assign colon     = sec_ones_q[0];

endmodule

// File: tb/tb_time_counter_bcd.sv
// Directed bench for time_counter_bcd at TICKS_PER_SEC=4; set-mode cases run when CLOCK_SET_EN is defined.
module tb_time_counter_bcd;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       inc_min = 1'b0;
  logic       inc_hour = 1'b0;
  logic [3:0] hour_tens, hour_ones, min_tens, min_ones;
  logic       sec_pulse, colon;

  int n_chk = 0;
  int n_err = 0;
  int pulses;

  time_counter_bcd #(.TICKS_PER_SEC(4), .PS_W(3)) u_dut (
    .clk(clk), .reset(reset), .inc_min(inc_min), .inc_hour(inc_hour),
    .hour_tens(hour_tens), .hour_ones(hour_ones), .min_tens(min_tens),
    .min_ones(min_ones), .sec_pulse(sec_pulse), .colon(colon)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] hhmm();
    return {hour_tens, hour_ones, min_tens, min_ones};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance n posedges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  initial begin
    // Reset state and first sec_pulse latency
    step(2);
    do_reset();
    chk("rst_digits", 32'(hhmm()), 32'h0000);
    chk("rst_pulse",  32'(sec_pulse), 0);
    chk("rst_colon",  32'(colon), 0);
    step(3);
    chk("pre_first_pulse", 32'(sec_pulse), 0);
    step(1);
    chk("first_pulse", 32'(sec_pulse), 1);
    chk("first_colon", 32'(colon), 1);
    step(1);
    chk("pulse_one_cycle", 32'(sec_pulse), 0);

    // One minute of free running, counting pulses
    do_reset();
    pulses = 0;
    for (int i = 0; i < 240; i++) begin
      step(1);
      if (sec_pulse) pulses++;
    end
    chk("min_1_digits", 32'(hhmm()), 32'h0001);
    chk("min_1_colon",  32'(colon), 0);
    chk("pulse_count",  32'(pulses), 60);
    step(2400 - 240 - 1);
    chk("min_9_59", 32'(hhmm()), 32'h0009);
    step(1);
    chk("min_10", 32'(hhmm()), 32'h0010);
    step(14400 - 2400 - 1);
    chk("hour_pre", 32'(hhmm()), 32'h0059);
    step(1);
    chk("hour_1", 32'(hhmm()), 32'h0100);

    // Reset mid-second
    do_reset();
    step(250);
    chk("mid_pre_reset", 32'(hhmm()), 32'h0001);
    do_reset();
    chk("mid_rst_digits", 32'(hhmm()), 32'h0000);
    chk("mid_rst_colon",  32'(colon), 0);
    step(3);
    chk("mid_no_pulse", 32'(sec_pulse), 0);
    step(1);
    chk("mid_pulse", 32'(sec_pulse), 1);

`ifdef CLOCK_SET_EN
    // Set to 23:59, then roll over to 00:00
    do_reset();
    inc_hour = 1'b1;
    step(23);
    inc_hour = 1'b0;
    chk("set_h23", 32'(hhmm()), 32'h2300);
    inc_min = 1'b1;
    step(59);
    inc_min = 1'b0;
    chk("set_2359", 32'(hhmm()), 32'h2359);
    step(239);
    chk("roll_pre", 32'(hhmm()), 32'h2359);
    chk("roll_pre_colon", 32'(colon), 1);
    step(1);
    chk("roll_post", 32'(hhmm()), 32'h0000);
    chk("roll_post_colon", 32'(colon), 0);

    // Minutes wrap without carrying into hours
    do_reset();
    inc_min = 1'b1;
    step(60);
    inc_min = 1'b0;
    chk("min_wrap", 32'(hhmm()), 32'h0000);
    step(3);
    inc_hour = 1'b1;
    step(1);
    inc_hour = 1'b0;
    chk("tc_set_hour", 32'(hhmm()), 32'h0100);
    chk("tc_no_pulse", 32'(sec_pulse), 0);
    chk("tc_colon", 32'(colon), 0);
    step(3);
    chk("tc_restart_quiet", 32'(sec_pulse), 0);
    step(1);
    chk("tc_restart_pulse", 32'(sec_pulse), 1);
    inc_min = 1'b1;
    inc_hour = 1'b1;
    step(1);
    inc_min = 1'b0;
    inc_hour = 1'b0;
    chk("both_set", 32'(hhmm()), 32'h0201);

    // Reset at 12:34 mid-second
    do_reset();
    inc_hour = 1'b1;
    step(12);
    inc_hour = 1'b0;
    inc_min = 1'b1;
    step(34);
    inc_min = 1'b0;
    step(6);
    chk("t1234", 32'(hhmm()), 32'h1234);
    do_reset();
    chk("t1234_rst", 32'(hhmm()), 32'h0000);
    chk("t1234_colon", 32'(colon), 0);
    step(3);
    chk("t1234_quiet", 32'(sec_pulse), 0);
    step(1);
    chk("t1234_pulse", 32'(sec_pulse), 1);
`else
    // Set inputs have no effect in this build
    do_reset();
    for (int i = 0; i < 240; i++) begin
      inc_min  = i[0];
      inc_hour = ~i[0];
      step(1);
      if (i == 99) begin
        chk("ign_100_digits", 32'(hhmm()), 32'h0000);
        chk("ign_100_colon",  32'(colon), 1);
      end
    end
    inc_min  = 1'b0;
    inc_hour = 1'b0;
    chk("ign_240_digits", 32'(hhmm()), 32'h0001);
    chk("ign_240_pulse",  32'(sec_pulse), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
